serial_subtractor: RTL and testbench
====================================

// Module: serial_subtractor
//
// PURPOSE
//   Bit-serial two's-complement subtractor: diff = a - b, computed LSB-first, one bit per clock.
//   Built around a gate-level full-subtractor cell (the inverse arithmetic cell to the team's full adder).
//   Gives a low-area subtract path for control/datapath blocks that tolerate WIDTH-cycle latency.
//   Uses a start/busy/done handshake.
//
// PARAMETERS
//   WIDTH  8  operand/result width in bits (>=2)
//
// PORTS
//   clk         in   1      single clock, rising edge
//   rst         in   1      synchronous, active-high reset
//   start       in   1      request; operands sampled on the same edge
//   a           in   WIDTH  minuend
//   b           in   WIDTH  subtrahend
//   busy        out  1      high while bits are being processed
//   done        out  1      one-cycle pulse: diff/borrow_out valid
//   diff        out  WIDTH  a - b mod 2^WIDTH; held until next completion
//   borrow_out  out  1      final borrow (1 when a < b unsigned)
//   ovf         out  1      signed overflow; exists only with SERIAL_SUB_OVF_EN
//
// BEHAVIOUR
//   - Reset:
//     - state=IDLE; busy, done, diff, borrow_out and ovf all 0.
//     - Internal shift registers, borrow flop and bit counter cleared.
//   - FSM states:
//     - IDLE: start=1 -> RUN; a and b captured; borrow flop=0; counter=0.
//     - RUN: one bit per cycle; when counter==WIDTH-1 -> DONE; otherwise counter+1.
//     - DONE: lasts one cycle, done=1. Then start=1 -> RUN (back-to-back), else -> IDLE.
//   - Bit cell, with bin = borrow flop:
//     - d    = a_i ^ b_i ^ bin
//     - bout = (~a_i & b_i) | (~(a_i ^ b_i) & bin)
//     - d shifts into result register MSB; a/b shift right; borrow flop <= bout.
//   - Latency:
//     - start sampled at edge T -> bit i processed in cycle T+1+i.
//     - done=1 during cycle T+WIDTH+1; back-to-back throughput is one op per WIDTH+1 cycles.
//   - Output timing:
//     - diff/borrow_out (and ovf) load on the edge entering DONE.
//     - They are stable from then until the next DONE entry and never toggle mid-run.
//   - busy=1 exactly in RUN; done=1 exactly in DONE; busy and done are never both 1.
//   - start while busy: ignored, operands not re-sampled, no error flag.
//   - rst mid-RUN: abort immediately, all outputs to reset values, no done pulse.
//   - Boundaries:
//     - a==b -> diff=0, borrow_out=0.
//     - a=0, b=2^WIDTH-1 -> diff=1, borrow_out=1 (wrap-around).
//
// CONFIGURATION
//   SERIAL_SUB_OVF_EN defined:
//     - Port ovf present.
//     - ovf = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the operands captured at start.
//     - ovf updates with diff; reset value 0.
//   SERIAL_SUB_OVF_EN undefined:
//     - Port ovf and its logic absent; all other behaviour identical.
//
// STRUCTURE
//   Package serial_sub_pkg:
//     - state typedef {IDLE, RUN, DONE} (2-bit).
//     - SERIAL_SUB_WIDTH_DEF = 8.
//   Sub-module full_subtractor(d, bout, a, b, bin):
//     - Pure gate primitives (xor/and/or/not), instantiated once.
//   Top level holds the FSM, counter ($clog2(WIDTH) bits), operand shift registers,
//   result register and borrow flop.
//
// TESTING (WIDTH=8; check done asserted exactly 9 cycles after the start edge)
//   1. a=0x05, b=0x03, start -> diff=0x02, borrow_out=0, one-cycle done pulse.
//   2. a=0x03, b=0x05 -> diff=0xFE, borrow_out=1.
//      Then a=0x00, b=0xFF -> diff=0x01, borrow_out=1.
//   3. a=0x5A, b=0x5A -> diff=0x00, borrow_out=0.
//      Then start held high through DONE -> second op starts back-to-back with correct result.
//   4. a=0x10, b=0x01 started; mid-RUN start with a=0xFF, b=0xFF -> ignored; result 0x0F, borrow_out=0.
//   5. Start a=0x80, b=0x01; rst asserted at cycle 4 of RUN -> all outputs 0, no done.
//      Then a=0x20, b=0x10 -> diff=0x10.
//   6. (SERIAL_SUB_OVF_EN) a=0x80, b=0x01 -> diff=0x7F, ovf=1.
//      Then a=0x7F, b=0x01 -> diff=0x7E, ovf=0.

Source files
------------

// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor built from gate primitives: d = a - b - bin.
module full_subtractor (
  output logic d,
  output logic bout,
  input  logic a,
  input  logic b,
  input  logic bin
);

  logic t, na, nt, g, p;

  xor x0 (t, a, b);
  xor x1 (d, t, bin);
  not n0 (na, a);
  not n1 (nt, t);
  and g0 (g, na, b);
  and g1 (p, nt, bin);
  or  o0 (bout, g, p);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b, LSB first, one bit per clock with start/busy/done handshake.
// Optional signed-overflow output is enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [WIDTH-2:0] res_sh;
  logic             bq;
  logic             d, bout;
  logic [WIDTH-1:0] res_next;

  full_subtractor u_fs (
    .d   (d),
    .bout(bout),
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (bq)
  );

  // Newest bit enters at the MSB; on the last bit this is the full result.
  assign res_next = {d, res_sh};

  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      bq         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state <= RUN;
            a_sh  <= a;
            b_sh  <= b;
            bq    <= 1'b0;
            cnt   <= '0;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next[WIDTH-1:1];
          bq     <= bout;
          if (cnt == LAST) begin
            state      <= DONE;
            diff       <= res_next;
            borrow_out <= bout;
`ifdef SERIAL_SUB_OVF_EN
            // On the last bit the shift registers hold the captured operand sign bits.
            ovf        <= (a_sh[0] != b_sh[0]) && (d != a_sh[0]);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [W-1:0] a, b, diff;
  logic         busy, done, borrow_out;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  int vectors = 0;
  int miscompares = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .diff      (diff),
    .borrow_out(borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic logic [W-1:0] m_diff(input int x, input int y);
    return W'((x - y + (1 << W)) % (1 << W));
  endfunction

  function automatic logic m_borrow(input int x, input int y);
    return x < y;
  endfunction

  function automatic logic m_ovf(input int x, input int y);
    int sx, sy, r;
    sx = (x >= (1 << (W-1))) ? x - (1 << W) : x;
    sy = (y >= (1 << (W-1))) ? y - (1 << W) : y;
    r  = sx - sy;
    return (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
  endfunction

  // Called at a negedge: presents the request for one rising edge.
  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; a = x; b = y;
    @(posedge clk);
    #1 start = 1'b0; a = W'($urandom); b = W'($urandom);
  endtask

  // Walks negedges k0+1.. after the start edge until done; returns k at done (or -1).
  task automatic wait_done(input int k0, input logic [W-1:0] hold, output int lat);
    lat = -1;
    for (int k = k0 + 1; k <= 20; k++) begin
      @(negedge clk);
      chk("busy_done_excl", {31'd0, busy & done}, 32'd0);
      if (done) begin
        lat = k;
        break;
      end
      chk("diff_stable", {24'd0, diff}, {24'd0, hold});
    end
  endtask

  task automatic check_res(input string tag, input int x, input int y, input int lat);
    chk({tag, "_lat"}, lat, 32'd9);
    chk({tag, "_diff"}, {24'd0, diff}, {24'd0, m_diff(x, y)});
    chk({tag, "_borrow"}, {31'd0, borrow_out}, {31'd0, m_borrow(x, y)});
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, "_ovf"}, {31'd0, ovf}, {31'd0, m_ovf(x, y)});
`endif
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [W-1:0] hold;
    int lat;
    hold = diff;
    issue(x, y);
    wait_done(0, hold, lat);
    check_res(tag, int'(x), int'(y), lat);
    @(negedge clk);
    chk({tag, "_pulse"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int lat, seen;
    logic [W-1:0] hold, x, y;

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_diff", {24'd0, diff}, 32'd0);
    chk("rst_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    @(negedge clk);

    do_op("t1", 8'h05, 8'h03);
    do_op("t2a", 8'h03, 8'h05);
    do_op("t2b", 8'h00, 8'hFF);
    do_op("t3a", 8'h5A, 8'h5A);

    // Back-to-back: start held through DONE.
    hold = diff;
    issue(8'h33, 8'h44);
    wait_done(0, hold, lat);
    check_res("b2b1", 8'h33, 8'h44, lat);
    hold = diff;
    issue(8'hC3, 8'h12);
    wait_done(0, hold, lat);
    check_res("b2b2", 8'hC3, 8'h12, lat);
    @(negedge clk);
    chk("b2b_pulse", {31'd0, done}, 32'd0);

    // Start while busy is ignored.
    hold = diff;
    issue(8'h10, 8'h01);
    repeat (2) @(negedge clk);
    start = 1'b1; a = 8'hFF; b = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done(3, hold, lat);
    check_res("t4", 8'h10, 8'h01, lat);
    @(negedge clk);

    // Reset mid-run aborts with no done pulse.
    issue(8'h80, 8'h01);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_diff", {24'd0, diff}, 32'd0);
    chk("abort_borrow", {31'd0, borrow_out}, 32'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort_ovf", {31'd0, ovf}, 32'd0);
`endif
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done) seen++;
    end
    chk("abort_nodone", seen, 32'd0);
    do_op("t5", 8'h20, 8'h10);

`ifdef SERIAL_SUB_OVF_EN
    do_op("t6a", 8'h80, 8'h01);
    do_op("t6b", 8'h7F, 8'h01);
`endif

    for (int i = 0; i < 16; i++) begin
      x = W'($urandom);
      y = (i % 5 == 0) ? x : W'($urandom);
      do_op("rnd", x, y);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
